// File: rtl/decode_issue_stage.sv
// ID stage with ID/EX pipeline register: RV32I field decode, register-file read with WB bypass,
// load-use bubble insertion with IF stall, EX flush handling and a saturating bubble counter.
module decode_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_insn,
    input  logic             flush,
    output logic             stall_if,
    output logic [31:0]      rf_addr_rs1,
    output logic [31:0]      rf_addr_rs2,
    input  logic [31:0]      rf_data_rs1,
    input  logic [31:0]      rf_data_rs2,
    input  logic             wb_write_en,
    input  logic [4:0]       wb_addr_rd,
    input  logic [31:0]      wb_data_rd,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [31:0]      ex_insn,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] hazard_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        reg_write;
    logic        is_load;
    logic        illegal;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        hazard;

    assign op  = if_insn[6:0];
    assign rd  = if_insn[11:7];
    assign rs1 = if_insn[19:15];
    assign rs2 = if_insn[24:20];

    assign rf_addr_rs1 = {27'd0, rs1};
    assign rf_addr_rs2 = {27'd0, rs2};

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        reg_write = (rd != 5'd0);
        is_load   = (op == OP_LOAD);
        illegal   = 1'b1;
        if (op inside {OP_LUI, OP_AUIPC, OP_JAL})
            uses_rs1 = 1'b0;
        if (op inside {OP_REG, OP_STORE, OP_BRANCH})
            uses_rs2 = 1'b1;
        if (op inside {OP_STORE, OP_BRANCH})
            reg_write = 1'b0;
        if (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                       OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM})
            illegal = 1'b0;
    end

    // x0 reads as zero even when writeback targets it; WB->ID bypass covers the same-cycle write.
    always_comb begin
        rs1_data = rf_data_rs1;
        rs2_data = rf_data_rs2;
        if (rs1 == 5'd0)
            rs1_data = '0;
        else if (wb_write_en && wb_addr_rd == rs1)
            rs1_data = wb_data_rd;
        if (rs2 == 5'd0)
            rs2_data = '0;
        else if (wb_write_en && wb_addr_rd == rs2)
            rs2_data = wb_data_rd;
    end

    assign hazard = if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

    assign stall_if = hazard && !flush;

    // NOTE: sequential state uses non-blocking assignments so each field samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_insn      <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!flush && !hazard && if_valid) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_insn      <= if_insn;
            ex_rs1_data  <= rs1_data;
            ex_rs2_data  <= rs2_data;
            ex_rd        <= rd;
            ex_reg_write <= reg_write;
            ex_is_load   <= is_load;
            ex_illegal   <= illegal;
        end else begin
            // Flush, load-use hazard and idle IF all load a fully zeroed bubble.
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_insn      <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_illegal   <= 1'b0;
        end
    end

    // Only bubbles actually caused by the hazard count; a simultaneous flush takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hazard_count <= '0;
        else if (stall_if && hazard_count != {CNT_W{1'b1}})
            hazard_count <= hazard_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: a behavioural ID/EX model checked every cycle,
// plus directed load-use, bypass, flush, reset and saturation scenarios with literal expectations.
module tb_decode_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] LW_X5    = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] ADD_X6   = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] LW_X0    = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] ADD_X6_0 = 32'h00200333;  // add  x6,x0,x2
    localparam logic [31:0] ADDI_X6  = 32'h00128313;  // addi x6,x5,1
    localparam logic [31:0] LUI_X5   = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] ADD_X8   = 32'h00738433;  // add  x8,x7,x7
    localparam logic [31:0] ADD_X9   = 32'h000004B3;  // add  x9,x0,x0
    localparam logic [31:0] ILLEGAL  = 32'h0000007F;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             if_valid = 1'b0;
    logic [XLEN-1:0]  if_pc = '0;
    logic [31:0]      if_insn = '0;
    logic             flush = 1'b0;
    logic             stall_if;
    logic [31:0]      rf_addr_rs1;
    logic [31:0]      rf_addr_rs2;
    logic [31:0]      rf_data_rs1;
    logic [31:0]      rf_data_rs2;
    logic             wb_write_en = 1'b0;
    logic [4:0]       wb_addr_rd = '0;
    logic [31:0]      wb_data_rd = '0;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [31:0]      ex_insn;
    logic [31:0]      ex_rs1_data;
    logic [31:0]      ex_rs2_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic             ex_illegal;
    logic [CNT_W-1:0] hazard_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] rf_mem [32];

    decode_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
        .flush(flush), .stall_if(stall_if), .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
        .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2), .wb_write_en(wb_write_en),
        .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_insn(ex_insn), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal),
        .hazard_count(hazard_count)
    );

    always #5 clock = ~clock;

    // Bench-side register file answering the DUT's read addresses.
    assign rf_data_rs1 = rf_mem[rf_addr_rs1[4:0]];
    assign rf_data_rs2 = rf_mem[rf_addr_rs2[4:0]];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        ill;
    } ex_t;

    ex_t m_ex = '0;
    int  m_cnt = 0;

    function automatic logic [31:0] m_operand(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (wb_write_en && wb_addr_rd == rs) return wb_data_rd;
        return rf_mem[rs];
    endfunction

    function automatic bit m_hazard();
        logic [6:0] op = if_insn[6:0];
        bit u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        bit u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return if_valid && m_ex.valid && m_ex.ld && m_ex.rd != 0 &&
               ((u1 && if_insn[19:15] == m_ex.rd) || (u2 && if_insn[24:20] == m_ex.rd));
    endfunction

    function automatic ex_t m_issue();
        ex_t e;
        logic [6:0] op = if_insn[6:0];
        e.valid = 1'b1;
        e.pc    = if_pc;
        e.insn  = if_insn;
        e.rs1d  = m_operand(if_insn[19:15]);
        e.rs2d  = m_operand(if_insn[24:20]);
        e.rd    = if_insn[11:7];
        e.rw    = !(op inside {7'b0100011, 7'b1100011}) && if_insn[11:7] != 0;
        e.ld    = (op == 7'b0000011);
        e.ill   = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                               7'b1110011});
        return e;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ex  <= '0;
            m_cnt <= 0;
        end else if (flush) begin
            m_ex <= '0;
        end else if (m_hazard()) begin
            m_ex  <= '0;
            m_cnt <= (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (if_valid) begin
            m_ex <= m_issue();
        end else begin
            m_ex <= '0;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("stall_if",     32'(stall_if),     32'(m_hazard() && !flush));
            check("rf_addr_rs1",  rf_addr_rs1,       32'(if_insn[19:15]));
            check("rf_addr_rs2",  rf_addr_rs2,       32'(if_insn[24:20]));
            check("ex_valid",     32'(ex_valid),     32'(m_ex.valid));
            check("ex_pc",        ex_pc,             m_ex.pc);
            check("ex_insn",      ex_insn,           m_ex.insn);
            check("ex_rs1_data",  ex_rs1_data,       m_ex.rs1d);
            check("ex_rs2_data",  ex_rs2_data,       m_ex.rs2d);
            check("ex_rd",        32'(ex_rd),        32'(m_ex.rd));
            check("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
            check("ex_is_load",   32'(ex_is_load),   32'(m_ex.ld));
            check("ex_illegal",   32'(ex_illegal),   32'(m_ex.ill));
            check("hazard_count", 32'(hazard_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                         input bit fl = 1'b0, input bit we = 1'b0,
                         input logic [4:0] wa = 5'd0, input logic [31:0] wd = 32'd0);
        if_valid    = v;
        if_pc       = pc;
        if_insn     = insn;
        flush       = fl;
        wb_write_en = we;
        wb_addr_rd  = wa;
        wb_data_rd  = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i * 32'h11);
        rf_mem[0] = 32'hBAD0_0000;

        #1 reset = 1'b1;
        #12 reset = 1'b0;
        tick();
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset hazard_count", 32'(hazard_count), 32'd0);
        cmp_en = 1'b1;

        // Load-use on rs1: one bubble, then the dependent add issues.
        drive(1, 32'h100, LW_X5); tick();
        drive(1, 32'h104, ADD_X6); #1;
        check("lu stall_if", 32'(stall_if), 32'd1);
        tick();
        check("lu bubble ex_valid", 32'(ex_valid), 32'd0);
        check("lu hazard_count", 32'(hazard_count), 32'd1);
        check("lu stall released", 32'(stall_if), 32'd0);
        tick();
        check("lu add issued", ex_insn, ADD_X6);
        check("lu add rs1", ex_rs1_data, 32'h1000_0055);
        check("lu add rs2", ex_rs2_data, 32'h1000_0022);

        // Load to x0 never stalls.
        drive(1, 32'h108, LW_X0); tick();
        drive(1, 32'h10C, ADD_X6_0); #1;
        check("x0 no stall", 32'(stall_if), 32'd0);
        tick();
        check("x0 add issued", 32'(ex_valid), 32'd1);
        check("x0 rs1 zero", ex_rs1_data, 32'd0);

        // I-type consumer stalls; lui does not read rs1.
        drive(1, 32'h110, LW_X5); tick();
        drive(1, 32'h114, ADDI_X6); #1;
        check("addi stall", 32'(stall_if), 32'd1);
        tick(); tick();
        check("addi issued", ex_insn, ADDI_X6);
        drive(1, 32'h118, LW_X5); tick();
        drive(1, 32'h11C, LUI_X5); #1;
        check("lui no stall", 32'(stall_if), 32'd0);
        tick();
        check("lui issued", ex_insn, LUI_X5);

        // WB->ID bypass, and no bypass into x0.
        rf_mem[7] = 32'd0;
        drive(1, 32'h120, ADD_X8, 0, 1, 5'd7, 32'hDEADBEEF); tick();
        check("bypass rs1", ex_rs1_data, 32'hDEADBEEF);
        check("bypass rs2", ex_rs2_data, 32'hDEADBEEF);
        drive(1, 32'h124, ADD_X9, 0, 1, 5'd0, 32'd5); tick();
        check("wb x0 rs1", ex_rs1_data, 32'd0);
        check("wb x0 rs2", ex_rs2_data, 32'd0);

        // Flush beats hazard.
        drive(1, 32'h128, LW_X5); tick();
        drive(1, 32'h12C, ADD_X6, 1); #1;
        check("flush stall_if", 32'(stall_if), 32'd0);
        tick();
        check("flush bubble", 32'(ex_valid), 32'd0);
        check("flush count kept", 32'(hazard_count), 32'd2);

        // Async reset in the middle of a stall.
        drive(1, 32'h130, LW_X5); tick();
        drive(1, 32'h134, ADD_X6); #1;
        check("pre-reset stall", 32'(stall_if), 32'd1);
        reset = 1'b1; #1;
        check("mid reset ex_valid", 32'(ex_valid), 32'd0);
        check("mid reset ex_insn", ex_insn, 32'd0);
        check("mid reset count", 32'(hazard_count), 32'd0);
        check("mid reset stall_if", 32'(stall_if), 32'd0);
        #1 reset = 1'b0;
        tick();

        // Five load-use hazards saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 32'(i * 8), LW_X5); tick();
            drive(1, 32'h204 + 32'(i * 8), ADD_X6); tick();
        end
        check("saturated count", 32'(hazard_count), 32'd3);

        drive(1, 32'h300, ILLEGAL); tick();
        check("illegal flag", 32'(ex_illegal), 32'd1);
        check("illegal valid", 32'(ex_valid), 32'd1);

        drive(0, 32'h0, 32'h0); tick();
        check("idle bubble", 32'(ex_valid), 32'd0);
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
